// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package serial_addsub_pkg;

  // Default operand width, matching the 4-bit ripple-carry parallel adder it sits beside.
  localparam int unsigned DefaultWidth = 4;

  // State encodings.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  // Bit-counter width; a single bit is kept even for degenerate widths.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full-adder cell; the only arithmetic element of the serial unit.
module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  // Propagate term shared by sum and carry.
  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (w_p & i_ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell plus a carry flop, LSB first,
// one bit per clock. Subtraction is a + ~b + ~cin, so cout is a no-borrow flag.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  // Architectural state.
  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  // Next-state values.
  state_e           w_state_d;
  logic [WIDTH-1:0] w_a_d;
  logic [WIDTH-1:0] w_b_d;
  logic [WIDTH-1:0] w_r_d;
  logic             w_carry_d;
  logic [CntW-1:0]  w_cnt_d;
  logic [WIDTH-1:0] w_s_d;
  logic             w_cout_d;
  logic             w_busy_d;
  logic             w_done_d;

  // Full-adder cell outputs for the current bit.
  logic             w_sum;
  logic             w_co;
  logic             w_last;

  fa u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  assign w_last = (r_cnt == LastCnt);

  // Next-state and datapath decode; everything holds unless a branch says otherwise.
  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_r_d     = r_r;
    w_carry_d = r_carry;
    w_cnt_d   = r_cnt;
    w_s_d     = r_s;
    w_cout_d  = r_cout;

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          // Accept: operands are captured here and ignored for the rest of the op.
          w_state_d = StRun;
          w_a_d     = i_a;
          w_b_d     = i_sub ? ~i_b : i_b;
          w_carry_d = i_cin ^ i_sub;
          w_cnt_d   = '0;
          w_r_d     = '0;
        end else begin
          w_state_d = StIdle;
        end
      end
      StRun: begin
        w_r_d     = {w_sum, r_r[WIDTH-1:1]};
        w_carry_d = w_co;
        w_a_d     = {1'b0, r_a[WIDTH-1:1]};
        w_b_d     = {1'b0, r_b[WIDTH-1:1]};
        w_cnt_d   = r_cnt + CntW'(1);
        if (w_last) begin
          // Publish the result on the edge that consumes the MSB.
          w_state_d = StDone;
          w_s_d     = {w_sum, r_r[WIDTH-1:1]};
          w_cout_d  = w_co;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Status flags are registered from the next state so outputs come straight off flops.
    w_busy_d = (w_state_d == StRun);
    w_done_d = (w_state_d == StDone);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_r     <= w_r_d;
      r_carry <= w_carry_d;
      r_cnt   <= w_cnt_d;
      r_s     <= w_s_d;
      r_cout  <= w_cout_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed table, protocol and reset
// sequences, then random operations against an arithmetic reference model.
module tb_serial_addsub;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         busy;
  logic         done;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] prev_s;
  logic         prev_cout;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_sub   (sub),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_s     (s),
    .o_cout  (cout),
    .o_busy  (busy),
    .o_done  (done)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {cout, s}.
  function automatic logic [W:0] model(input logic m_sub, input logic [W-1:0] m_a,
                                       input logic [W-1:0] m_b, input logic m_cin);
    int ia;
    int ib;
    int ic;
    int r;
    logic [W-1:0] rs;
    logic rc;
    ia = int'(m_a);
    ib = int'(m_b);
    ic = m_cin ? 1 : 0;
    if (!m_sub) begin
      r  = ia + ib + ic;
      rs = W'(r % (1 << W));
      rc = (r >= (1 << W));
    end else begin
      r  = ia - ib - ic + (1 << W);
      rs = W'(r % (1 << W));
      rc = (ia >= ib + ic);
    end
    return {rc, rs};
  endfunction

  // Drives one operation from a negedge and returns at the negedge inside the done cycle.
  // poke >= 0 re-asserts start with junk operands at that RUN sample to check it is ignored.
  task automatic run_op(input logic op_sub, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input logic [W-1:0] exp_s, input logic exp_cout,
                        input int poke, input string tag);
    int busy_cnt;
    int early;
    int hold_bad;
    busy_cnt = 0;
    early    = 0;
    hold_bad = 0;
    start = 1'b1;
    sub   = op_sub;
    a     = op_a;
    b     = op_b;
    cin   = op_cin;
    @(negedge clk);
    for (int c = 0; c < int'(W); c++) begin
      if (busy) busy_cnt++;
      if (done) early++;
      if (s !== prev_s || cout !== prev_cout) hold_bad++;
      start = (c == poke);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy cycles"}, busy_cnt, W);
    check({tag, " early done"}, early, 0);
    check({tag, " output hold during run"}, hold_bad, 0);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy in done"}, 32'(busy), 0);
    check({tag, " s"}, 32'(s), 32'(exp_s));
    check({tag, " cout"}, 32'(cout), 32'(exp_cout));
    prev_s    = exp_s;
    prev_cout = exp_cout;
  endtask

  // Idle cycles: no activity, result held.
  task automatic idle(input int n, input string tag);
    int bad;
    bad   = 0;
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done || busy || s !== prev_s || cout !== prev_cout) bad++;
    end
    check({tag, " idle hold"}, bad, 0);
  endtask

  initial begin
    logic [W:0] exp;
    int         extra_done;

    vecs[0] = '{sub: 1'b0, a: 4'd5,  b: 4'd3,  cin: 1'b0, s: 4'd8,  cout: 1'b0};
    vecs[1] = '{sub: 1'b0, a: 4'd15, b: 4'd1,  cin: 1'b0, s: 4'd0,  cout: 1'b1};
    vecs[2] = '{sub: 1'b0, a: 4'd15, b: 4'd15, cin: 1'b1, s: 4'd15, cout: 1'b1};
    vecs[3] = '{sub: 1'b1, a: 4'd9,  b: 4'd4,  cin: 1'b0, s: 4'd5,  cout: 1'b1};
    vecs[4] = '{sub: 1'b1, a: 4'd3,  b: 4'd5,  cin: 1'b0, s: 4'd14, cout: 1'b0};
    vecs[5] = '{sub: 1'b1, a: 4'd4,  b: 4'd4,  cin: 1'b1, s: 4'd15, cout: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    check("reset s", 32'(s), 0);
    check("reset cout", 32'(cout), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    prev_s    = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, "post reset");

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, -1,
             $sformatf("vec%0d", i));
      idle(1 + (i % 2), $sformatf("vec%0d", i));
    end

    // start during RUN with different operands: ignored, not queued.
    run_op(1'b0, 4'd6, 4'd7, 1'b0, 4'd13, 1'b0, 1, "ignored start");
    idle(3, "ignored start");

    // start in the DONE cycle: accepted with no idle gap.
    run_op(1'b1, 4'd9, 4'd4, 1'b0, 4'd5, 1'b1, -1, "b2b first");
    run_op(1'b0, 4'd2, 4'd3, 1'b1, 4'd6, 1'b0, -1, "b2b second");
    idle(1, "b2b");

    // Reset in the second RUN cycle aborts with outputs cleared at once.
    start = 1'b1;
    sub   = 1'b0;
    a     = 4'd7;
    b     = 4'd6;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort s", 32'(s), 0);
    check("abort cout", 32'(cout), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    prev_s     = '0;
    prev_cout  = 1'b0;
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("abort no done", extra_done, 0);
    rst_n = 1'b1;
    idle(W + 2, "after abort");
    run_op(1'b0, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, -1, "post abort");
    idle(1, "post abort");

    // Random operations against the model, mixing back-to-back and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      logic         r_sub;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      logic         r_cin;
      r_sub = 1'($urandom);
      r_a   = W'($urandom);
      r_b   = W'($urandom);
      r_cin = 1'($urandom);
      exp   = model(r_sub, r_a, r_b, r_cin);
      run_op(r_sub, r_a, r_b, r_cin, exp[W-1:0], exp[W], -1, $sformatf("rand%0d", i));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)), $sformatf("rand%0d", i));
    end
    idle(2, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
